// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that multiplexes N native-bus masters onto one shared memory slave.
// Each grant covers one transfer; the arbiter returns to IDLE between grants.
module mem_bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [N_MASTERS-1:0]          grant
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(N_MASTERS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [N_MASTERS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]     owner_reg, owner_next;
    logic [IDX_W-1:0]     last_owner_reg, last_owner_next;
    logic [IDX_W-1:0]     winner;
    logic                 found;
    logic                 complete;

    logic [ADDR_W-1:0] addr_arr  [N_MASTERS];
    logic [DATA_W-1:0] wdata_arr [N_MASTERS];
    logic [STRB_W-1:0] wstrb_arr [N_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
            assign wstrb_arr[gi] = m_wstrb[gi*STRB_W +: STRB_W];
        end
    endgenerate

    // Search starts one past the last completed owner so every requester gets a turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            if (!found && m_valid[IDX_W'((int'(last_owner_reg) + k) % N_MASTERS)]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(last_owner_reg) + k) % N_MASTERS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(N_MASTERS - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        complete        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next         = BUSY;
                    owner_next         = winner;
                    grant_next         = '0;
                    grant_next[winner] = 1'b1;
                end
            end
            BUSY: begin
                // A slave response wins over a simultaneous withdrawal of the request.
                if (s_ready) begin
                    complete        = 1'b1;
                    last_owner_next = owner_reg;
                    state_next      = IDLE;
                    grant_next      = '0;
                end else if (!m_valid[owner_reg]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_comb begin
        s_valid = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (state_reg == BUSY) begin
            s_valid = m_valid[owner_reg];
            s_addr  = addr_arr[owner_reg];
            s_wdata = wdata_arr[owner_reg];
            s_wstrb = wstrb_arr[owner_reg];
        end
    end

    assign grant   = grant_reg;
    assign m_ready = complete ? grant_reg : '0;
    assign m_rdata = complete ? s_rdata : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    m_valid = '0;
    logic [N*32-1:0] m_addr = '0;
    logic [N*32-1:0] m_wdata = '0;
    logic [N*4-1:0]  m_wstrb = '0;
    logic [31:0]     m_rdata;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [31:0]     s_rdata = '0;
    logic            s_ready = 1'b0;
    logic [N-1:0]    grant;

    mem_bus_arbiter #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] f_addr  [N];
    logic [31:0] f_wdata [N];
    logic [3:0]  f_wstrb [N];

    // Model: current owner (-1 when idle) and last completed owner.
    int           cur  = -1;
    int           last = N - 1;
    logic [N-1:0] done_mask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle();
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        logic         exp_sv;
        logic [31:0]  ea, ew;
        logic [3:0]   es;
        bit           hit;
        exp_grant = '0;
        exp_ready = '0;
        exp_sv    = 1'b0;
        ea        = '0;
        ew        = '0;
        es        = '0;
        done_mask = '0;
        if (cur >= 0) begin
            exp_grant[cur] = 1'b1;
            exp_sv         = m_valid[cur];
            ea             = f_addr[cur];
            ew             = f_wdata[cur];
            es             = f_wstrb[cur];
            if (s_ready) exp_ready[cur] = 1'b1;
        end
        check("grant", 64'(grant), 64'(exp_grant));
        check("s_valid", 64'(s_valid), 64'(exp_sv));
        check("s_addr", 64'(s_addr), 64'(ea));
        check("s_wdata", 64'(s_wdata), 64'(ew));
        check("s_wstrb", 64'(s_wstrb), 64'(es));
        check("m_ready", 64'(m_ready), 64'(exp_ready));
        if (exp_ready != '0) check("m_rdata", 64'(m_rdata), 64'(s_rdata));

        if (cur < 0) begin
            hit = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!hit && m_valid[(last + k) % N]) begin
                    hit = 1'b1;
                    cur = (last + k) % N;
                end
            end
        end else if (s_ready) begin
            $display("txn master=%0d addr=%h wdata=%h wstrb=%h rdata=%h",
                     cur, f_addr[cur], f_wdata[cur], f_wstrb[cur], s_rdata);
            done_mask[cur] = 1'b1;
            last = cur;
            cur  = -1;
        end else if (!m_valid[cur]) begin
            $display("txn master=%0d aborted", cur);
            cur = -1;
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        m_valid = v;
        s_ready = rdy;
        s_rdata = rd;
        for (int i = 0; i < N; i++) begin
            m_addr[i*32 +: 32]  = f_addr[i];
            m_wdata[i*32 +: 32] = f_wdata[i];
            m_wstrb[i*4 +: 4]   = f_wstrb[i];
        end
        #1;
        model_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'(0));
        check({tag, "_s_valid"}, 64'(s_valid), 64'(0));
        check({tag, "_m_ready"}, 64'(m_ready), 64'(0));
    endtask

    logic [N-1:0] pending;
    logic [N-1:0] v;

    initial begin
        for (int i = 0; i < N; i++) begin
            f_addr[i]  = 32'h1000 * (i + 1);
            f_wdata[i] = 32'hA0A0_0000 + i;
            f_wstrb[i] = 4'h0;
        end
        // Reset held with requests and slave response present.
        m_valid = '1;
        s_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        check_reset_outputs("reset_hold");
        m_valid = '0;
        s_ready = 1'b0;
        rst     = 1'b1;

        // Contention from reset with a zero-wait slave: 01,00,10,00,01,...
        for (int c = 0; c < 8; c++) step(2'b11, 1'b1, 32'hC000_0000 + c);
        step(2'b00, 1'b0, 32'h0);

        // Single read from master 0 with three wait cycles.
        f_addr[0] = 32'h100;
        f_wstrb[0] = 4'h0;
        step(2'b01, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) step(2'b01, 1'b0, 32'h0);
        step(2'b01, 1'b1, 32'hDEAD_BEEF);
        step(2'b00, 1'b0, 32'h0);

        // Write from master 1 while master 0 carries distinct fields.
        f_addr[0] = 32'hFFFF_0000; f_wdata[0] = 32'h5555_AAAA; f_wstrb[0] = 4'h3;
        f_addr[1] = 32'h2000;      f_wdata[1] = 32'h1234_5678; f_wstrb[1] = 4'hF;
        step(2'b10, 1'b0, 32'h0);
        step(2'b10, 1'b0, 32'h0);
        step(2'b10, 1'b0, 32'h0);
        step(2'b10, 1'b1, 32'h0);
        step(2'b00, 1'b0, 32'h0);

        // Abort: master 0 completes, then master 1 owns and withdraws in its 2nd busy cycle.
        step(2'b01, 1'b0, 32'h0);
        step(2'b01, 1'b1, 32'h0BAD_0001);
        step(2'b00, 1'b0, 32'h0);
        step(2'b11, 1'b0, 32'h0);
        step(2'b11, 1'b0, 32'h0);
        step(2'b01, 1'b0, 32'h0);
        step(2'b01, 1'b0, 32'h0);
        step(2'b01, 1'b1, 32'h0BAD_0002);
        step(2'b00, 1'b0, 32'h0);

        // Withdrawal and response in the same cycle: response wins.
        step(2'b10, 1'b0, 32'h0);
        step(2'b00, 1'b1, 32'h7777_0000);

        // Slave noise while idle.
        for (int c = 0; c < 4; c++) step(2'b00, 1'b1, 32'hFACE_0000 + c);

        // Reset asserted between edges during a busy cycle.
        step(2'b10, 1'b0, 32'h0);
        step(2'b10, 1'b0, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        cur     = -1;
        last    = N - 1;
        m_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        step(2'b10, 1'b0, 32'h0);
        step(2'b10, 1'b1, 32'h1111_2222);
        step(2'b00, 1'b0, 32'h0);

        // Random traffic with held requests, occasional withdrawals and random slave waits.
        pending = '0;
        for (int c = 0; c < 600; c++) begin
            v = '0;
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(2) == 0)) begin
                    pending[i] = 1'b1;
                    f_addr[i]  = $urandom;
                    f_wdata[i] = $urandom;
                    f_wstrb[i] = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
                end
                if (pending[i] && ($urandom_range(15) == 0)) pending[i] = 1'b0;
                v[i] = pending[i];
            end
            step(v, ($urandom_range(9) < 4), $urandom);
            pending = pending & ~done_mask;
        end
        step('0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter N_MASTERS SHALL be a parameter with default 2 giving the number of requesters, legal range 2..8.
REQ-002 Parameter ADDR_W SHALL be a parameter with default 32 giving the native-bus address width.
REQ-003 Parameter DATA_W SHALL be a parameter with default 32 giving the native-bus data width.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-low reset.
REQ-006 Port m_valid SHALL be an input, N_MASTERS bits wide, carrying one request-valid bit per master.
REQ-007 Port m_addr SHALL be an input, N_MASTERS*ADDR_W bits wide, carrying each master's address with master i at bits [i*ADDR_W +: ADDR_W].
REQ-008 Port m_wdata SHALL be an input, N_MASTERS*DATA_W bits wide, carrying each master's write data.
REQ-009 Port m_wstrb SHALL be an input, N_MASTERS*DATA_W/8 bits wide, carrying each master's write strobes, where all-zero means read.
REQ-010 Port m_rdata SHALL be an output, DATA_W bits wide, carrying read data shared by all masters and valid only with that master's m_ready.
REQ-011 Port m_ready SHALL be an output, N_MASTERS bits wide, carrying a one-cycle completion pulse per master.
REQ-012 Port s_valid, s_addr, s_wdata, s_wstrb SHALL be outputs of widths 1, ADDR_W, DATA_W and DATA_W/8, forming the request to the shared memory slave.
REQ-013 Port s_rdata, s_ready SHALL be inputs of widths DATA_W and 1, forming the response from the shared memory slave.
REQ-014 Port grant SHALL be an output, N_MASTERS bits wide, carrying the one-hot current owner, all-zero when idle.

Function
REQ-015 The arbiter SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-016 In IDLE with any m_valid bit set, the arbiter SHALL register a one-hot grant for the winner and enter BUSY on the next edge.
REQ-017 The arbiter SHALL select the winner round-robin: search starts at index (last_owner+1) mod N_MASTERS, and the first set m_valid bit wins.
REQ-018 In IDLE with m_valid all zero, the FSM SHALL stay in IDLE and the grant SHALL stay zero.
REQ-019 In BUSY, s_valid SHALL equal m_valid[owner], and s_addr/s_wdata/s_wstrb SHALL be a combinational mux of the owner's fields.
REQ-020 In IDLE, s_valid SHALL be 0, and s_addr/s_wdata/s_wstrb SHALL be 0.
REQ-021 In BUSY with s_ready=1, m_ready[owner] SHALL be 1 in that same cycle, m_rdata SHALL equal s_rdata, last_owner SHALL take owner, and the FSM SHALL return to IDLE.
REQ-022 m_ready SHALL never have more than one bit set, and SHALL be all-zero in IDLE.
REQ-023 s_ready observed while in IDLE SHALL be ignored, with no m_ready pulse and no state change.
REQ-024 The added latency SHALL be exactly 1 cycle, from m_valid rising in IDLE to s_valid rising.
REQ-025 A zero-wait slave (s_ready in the first BUSY cycle) SHALL give 2 cycles from request to m_ready.
REQ-026 Back-to-back transactions SHALL include one IDLE cycle between grants, giving a maximum throughput of one transfer every 2 cycles.
REQ-027 If m_valid[owner] drops in BUSY before s_ready (an aborted request), the FSM SHALL return to IDLE with no m_ready pulse and last_owner unchanged.
REQ-028 If s_ready and the owner's valid drop occur in the same cycle, s_ready SHALL take precedence per REQ-021.
REQ-029 Requests from non-owners SHALL be held pending without any effect on the slave, and no master is starved: each waits at most N_MASTERS-1 transactions.
REQ-030 Grant SHALL not change while in BUSY, regardless of other m_valid activity.

Reset
REQ-031 Asserting rst low SHALL immediately force state=IDLE, grant=0, last_owner=N_MASTERS-1 (so master 0 has first priority), s_valid=0 and m_ready=0.
REQ-032 Reset asserted mid-transaction SHALL drop s_valid asynchronously and issue no m_ready pulse; the slave transaction is abandoned.
REQ-033 After rst deasserts, arbitration SHALL resume on the first rising clk edge at which m_valid is nonzero.

Verification
REQ-034 Single read: with N_MASTERS=2, m_valid=01, m_addr[0]=0x100 and wstrb=0, the slave responding s_ready after 3 BUSY cycles with s_rdata=0xDEADBEEF -> m_ready=01 for exactly one cycle with m_rdata=0xDEADBEEF, and grant 01->00.
REQ-035 Contention: with m_valid=11 held from reset and a zero-wait slave -> grant sequence 01,00,10,00,01,... and m_ready pulses alternating master 0 and master 1.
REQ-036 Write forwarding: master 1 with addr=0x2000, wdata=0x12345678 and wstrb=0xF -> s_addr, s_wdata and s_wstrb match exactly throughout BUSY, and master 0's fields are never visible on the slave port.
REQ-037 Abort: the owner drops m_valid in its 2nd BUSY cycle with s_ready=0 -> next cycle IDLE, no m_ready, and a pending master 0 is granted per the unchanged pointer.
REQ-038 Reset mid-operation: rst=0 asserted in BUSY between edges -> s_valid=0 and grant=0 immediately; after release, m_valid=10 is granted to master 1 within 1 cycle.
REQ-039 Idle noise: s_ready pulsed while IDLE -> m_ready stays 0 and state stays IDLE.
